// File: rtl/sy_uart_pkg.sv
// Shared definitions for the UART receive path.
//   UART_DATA_BITS : payload bits per frame (8N1 framing)
//   uart_state_e   : receiver FSM states
package sy_uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } uart_state_e;

endpackage

// File: rtl/sy_sync_fifo.sv
// Synchronous FIFO with a registered head word.
//   clk_i, rst_i        : clock, async active-low reset
//   push_i, data_i      : write request and data (ignored when full unless popping)
//   pop_i               : read request (ignored when empty)
//   data_o              : head entry (registered, 0 when empty)
//   full_o, empty_o     : registered status flags
//   count_o             : occupancy, 0..DEPTH
module sy_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             empty_q, empty_d, full_q, full_d;
    logic             push_ok, pop_ok;

    always_comb begin
        pop_ok   = pop_i && !empty_q;
        // A full FIFO still takes a write when a slot frees in the same cycle.
        push_ok  = push_i && (!full_q || pop_ok);
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        empty_d  = (count_d == '0);
        full_d   = (count_d == CW'(DEPTH));
        // Next head: the incoming word bypasses the array when it lands at the
        // new read pointer, since the array write only completes at this edge.
        if (empty_d) begin
            head_d = '0;
        end else if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
            head_d = data_i;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    assign data_o  = head_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign count_o = count_q;

endmodule

// File: rtl/sy_uart_rx.sv
// 8N1 UART receiver with byte buffer.
//   clk_i, rst_i    : clock, async active-low reset
//   rx_i            : asynchronous serial input, idle high
//   rx_data_o       : byte at buffer head
//   rx_valid_o      : buffer non-empty
//   rx_ready_i      : consumer accept; pop when valid && ready
//   frame_err_o     : one-cycle pulse on a low stop bit
//   overflow_o      : one-cycle pulse when a good byte is dropped (buffer full)
//   fifo_cnt_o      : buffer occupancy
module sy_uart_rx
    import sy_uart_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        rx_i,
    output logic [7:0]                  rx_data_o,
    output logic                        rx_valid_o,
    input  logic                        rx_ready_i,
    output logic                        frame_err_o,
    output logic                        overflow_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt_o
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

    uart_state_e               state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      sync1_q, sync2_q;
    logic                      frame_err_q, frame_err_d;
    logic                      overflow_q, overflow_d;
    logic                      rx_s, cnt_zero, push, pop, fifo_full, fifo_empty;

    assign rx_s     = sync2_q;
    assign cnt_zero = (cnt_q == '0);
    assign pop      = rx_ready_i && !fifo_empty;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                // Half-bit delay so every later sample lands mid-bit.
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = HALF_BIT;
                end
            end
            START: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rx_s) begin
                    state_d = IDLE;
                end else begin
                    state_d   = DATA;
                    cnt_d     = FULL_BIT;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d   = {rx_s, shift_q[UART_DATA_BITS-1:1]};
                    cnt_d     = FULL_BIT;
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rx_s) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                // Line held low (break): wait for it to return high before hunting.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        overflow_d = push && fifo_full && !pop;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            sync1_q     <= rx_i;
            sync2_q     <= sync1_q;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    sy_sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (shift_q),
        .pop_i   (pop),
        .data_o  (rx_data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt_o)
    );

    assign rx_valid_o  = !fifo_empty;
    assign frame_err_o = frame_err_q;
    assign overflow_o  = overflow_q;

endmodule

// File: doc/sy_uart_rx.md
SY_UART_RX -- requirements
Module: sy_uart_rx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16, meaning clock cycles per serial bit time (legal values: 4 or more).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning received-byte buffer entries (power of two, 2 or more).
REQ-003 SHALL have port clk_i  input  1  meaning the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_i  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port rx_i  input  1  meaning serial line from the SoC UART transmitter, asynchronous, idle high.
REQ-006 SHALL have port rx_data_o  output  8  meaning the byte at the buffer head.
REQ-007 SHALL have port rx_valid_o  output  1  meaning the buffer is non-empty and rx_data_o is valid.
REQ-008 SHALL have port rx_ready_i  input  1  meaning the consumer accepts a byte; a pop occurs when rx_valid_o and rx_ready_i are both high.
REQ-009 SHALL have port frame_err_o  output  1  meaning a one-cycle pulse when a stop bit is sampled low.
REQ-010 SHALL have port overflow_o  output  1  meaning a one-cycle pulse when a good byte is dropped because the buffer is full.
REQ-011 SHALL have port fifo_cnt_o  output  $clog2(FIFO_DEPTH)+1  meaning the current buffer occupancy.

Function
REQ-012 SHALL pass rx_i through a 2-flop synchronizer; all detection and sampling SHALL use the synchronized value (rx_s).
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-014 IDLE: on the first cycle rx_s is 0, go to START and load the baud counter with CLK_DIV/2-1.
REQ-015 START: when the counter reaches 0, sample rx_s. If 1, treat as a glitch and return to IDLE with no output. If 0, go to DATA, reload the counter with CLK_DIV-1, and clear the bit index.
REQ-016 DATA: each time the counter reaches 0, shift rx_s in LSB-first and reload the counter with CLK_DIV-1. After bit index 7, go to STOP.
REQ-017 STOP: when the counter reaches 0, sample rx_s.
- If 1: push the byte and go to IDLE.
- If 0: pulse frame_err_o, discard the byte, and go to WAIT_IDLE.
REQ-018 WAIT_IDLE SHALL remain until rx_s is 1, then go to IDLE; no start bit is detected in this state (break condition).
REQ-019 Push timing: the byte SHALL be visible on rx_data_o/rx_valid_o on the cycle after the stop-bit sample cycle when the buffer was empty.
REQ-020 A push SHALL be accepted when fifo_cnt_o < FIFO_DEPTH, or when a pop occurs in the same cycle. Otherwise the byte is dropped, overflow_o pulses, and stored contents are unchanged.
REQ-021 Simultaneous push and pop SHALL leave fifo_cnt_o unchanged and preserve FIFO order.
REQ-022 Read and write pointers SHALL wrap modulo FIFO_DEPTH; the occupancy counter SHALL never exceed FIFO_DEPTH or go below 0.
REQ-023 A pop with rx_valid_o low SHALL have no effect.
REQ-024 Back-to-back frames (a start bit immediately after the stop sample) SHALL be received without loss.

Reset
REQ-025 Asserting rst_i (low) SHALL immediately set:
- the FSM to IDLE;
- rx_data_o = 0, rx_valid_o = 0, frame_err_o = 0, overflow_o = 0, fifo_cnt_o = 0;
- pointers, counter and bit index to 0;
- both synchronizer flops to 1.
REQ-026 Reset mid-frame SHALL discard the partial byte. After release, the next valid start bit SHALL be received correctly.

Structure
REQ-027 The FSM state enum and a UART_DATA_BITS = 8 constant SHALL reside in shared package sy_uart_pkg.
REQ-028 The byte buffer SHALL be a sub-module, sy_sync_fifo, parameterized by width and depth, with push/pop/full/empty/count ports.
REQ-029 All outputs SHALL be registered.

Verification
REQ-030 CLK_DIV=16, rx_ready_i=1, send 0x55 (8N1): rx_data_o=0x55 with rx_valid_o high for 1 cycle; frame_err_o=0.
REQ-031 A 4-cycle low glitch on an idle line: no push, FSM back in IDLE; a following 0xA3 frame is received as 0xA3.
REQ-032 Send 0x3C with the stop bit held 0 for 2 bit times: frame_err_o pulses once, no push; a subsequent 0x7E is received.
REQ-033 FIFO_DEPTH=4, rx_ready_i=0, send 0x01..0x05: fifo_cnt_o=4, overflow_o pulses once. After raising rx_ready_i, reads return 0x01, 0x02, 0x03, 0x04.
REQ-034 Assert rst_i low during data bit 3 of 0xF0: all outputs are 0 immediately. After release, 0x0F is received correctly.
REQ-035 With the FIFO full, a pop coincides with a push of 0x99: no overflow, fifo_cnt_o stays 4, and 0x99 is the last entry read.
